// File: rtl/channel_post_pkg.sv
// Shared constants for the dot-channel post-processing slice.
// DATA_LEN mirrors the codebase-wide `data_len`; NUM_PART_DEFAULT is the
// number of partials per output pixel that the dot channel also counts to.
package channel_post_pkg;

  localparam int DATA_LEN         = 16;
  localparam int NUM_PART_DEFAULT = 6;
  localparam int CNT_W            = 4;

endpackage

// File: rtl/channel_post_relu_sat.sv
// relu_sat: combinational requantize step.
//   x_i     : signed IN_W value (accumulator plus bias)
//   r_o     : (x_i >>> SHIFT) clamped to [0, 2^(OUT_W-1)-1]
//   clamp_o : high when the upper clamp was applied
// Reusable by the pooling stage.
module relu_sat #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  x_i,
  output logic        [OUT_W-1:0] r_o,
  output logic                    clamp_o
);

  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};

  logic signed [IN_W-1:0] shifted;
  logic                   neg;
  logic                   too_big;

  assign shifted = x_i >>> SHIFT;
  assign neg     = shifted[IN_W-1];
  // Non-negative value exceeds MAX_POS iff any bit at or above OUT_W-1 is set.
  assign too_big = !neg && (|shifted[IN_W-2:OUT_W-1]);

  always_comb begin
    r_o = shifted[OUT_W-1:0];
    if (neg) begin
      r_o = '0;
    end else if (too_big) begin
      r_o = MAX_POS;
    end
  end

  assign clamp_o = too_big;

endmodule

// File: rtl/channel_post.sv
// channel_post: accumulates NUM_PART signed partial dot products into one
// output-pixel sum, adds BIAS, arithmetic-shifts by SHIFT, applies ReLU and
// saturates to DATA_LEN bits.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a new pixel, discarding any partial sum
//   in_valid  : d carries a valid partial product
//   d         : signed partial product
//   busy      : pixel in progress (start accepted, result not yet emitted)
//   valid     : one-cycle result strobe
//   q         : non-negative saturated result, held until the next result
//   ovf       : sticky high-saturation flag, cleared only by rst
module channel_post
  import channel_post_pkg::*;
#(
  parameter int NUM_PART = NUM_PART_DEFAULT,
  parameter int BIAS     = 0,
  parameter int SHIFT    = 0,
  parameter int ACC_W    = DATA_LEN + 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic signed [DATA_LEN-1:0] d,
  output logic                       busy,
  output logic                       valid,
  output logic        [DATA_LEN-1:0] q,
  output logic                       ovf
);

  if (NUM_PART < 1 || NUM_PART > 15) begin : g_bad_num_part
    $fatal(1, "channel_post: NUM_PART must be in 1..15");
  end
  if (ACC_W < DATA_LEN + $clog2(NUM_PART) + 1) begin : g_bad_acc_w
    $fatal(1, "channel_post: ACC_W too narrow for NUM_PART partials");
  end
  if (SHIFT < 0 || SHIFT > ACC_W - 1) begin : g_bad_shift
    $fatal(1, "channel_post: SHIFT must be in 0..ACC_W-1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_OUT
  } state_e;

  localparam logic signed [ACC_W-1:0] BIAS_W = ACC_W'(BIAS);
  localparam logic [CNT_W-1:0]        NP     = CNT_W'(NUM_PART);

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic                      valid_q, valid_d;
  logic        [DATA_LEN-1:0] q_q, q_d;
  logic                      ovf_q, ovf_d;

  logic signed [ACC_W-1:0]   d_ext;
  logic signed [ACC_W-1:0]   biased;
  logic        [DATA_LEN-1:0] res;
  logic                      res_clamp;
  logic        [CNT_W-1:0]   cnt_inc;

  assign d_ext   = ACC_W'(d);
  assign biased  = acc_q + BIAS_W;
  assign cnt_inc = cnt_q + 1'b1;

  relu_sat #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_LEN),
    .SHIFT (SHIFT)
  ) u_relu_sat (
    .x_i     (biased),
    .r_o     (res),
    .clamp_o (res_clamp)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    q_d     = q_q;
    ovf_d   = ovf_q;
    // start overrides every state; a same-cycle in_valid becomes partial #1
    // and, with a single partial per pixel, goes straight to OUT.
    if (start) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      if (in_valid) begin
        acc_d = d_ext;
        cnt_d = CNT_W'(1);
        if (NP == CNT_W'(1)) begin
          state_d = ST_OUT;
        end
      end
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            acc_d = acc_q + d_ext;
            cnt_d = cnt_inc;
            if (cnt_inc == NP) begin
              state_d = ST_OUT;
            end
          end
        end
        ST_OUT: begin
          valid_d = 1'b1;
          q_d     = res;
          ovf_d   = ovf_q | res_clamp;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = valid_q;
  assign q     = q_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_channel_post.sv
module tb_channel_post;

  localparam int ND = 4;
  // Four configurations share one stimulus stream.
  localparam int NPV [ND] = '{6, 6, 6, 1};
  localparam int BSV [ND] = '{0, -100, -1, 0};
  localparam int SHV [ND] = '{0, 2, 1, 0};

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] d = '0;

  logic        busy_w  [ND];
  logic        valid_w [ND];
  logic [15:0] q_w     [ND];
  logic        ovf_w   [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    channel_post #(
      .NUM_PART (NPV[g]),
      .BIAS     (BSV[g]),
      .SHIFT    (SHV[g]),
      .ACC_W    (24)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .d        (d),
      .busy     (busy_w[g]),
      .valid    (valid_w[g]),
      .q        (q_w[g]),
      .ovf      (ovf_w[g])
    );
  end

  // Reference model: pixel-in-progress flag, running sum, partial count.
  bit     m_active [ND];
  bit     m_ready  [ND];
  longint m_sum    [ND];
  int     m_n      [ND];
  bit     m_valid  [ND];
  int     m_q      [ND];
  bit     m_ovf    [ND];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit v,
                            input logic signed [15:0] dv);
    longint t;
    for (int k = 0; k < ND; k++) begin
      if (r) begin
        m_active[k] = 0; m_ready[k] = 0; m_sum[k] = 0; m_n[k] = 0;
        m_valid[k] = 0; m_q[k] = 0; m_ovf[k] = 0;
      end else begin
        m_valid[k] = 0;
        if (s) begin
          m_active[k] = 1; m_ready[k] = 0; m_sum[k] = 0; m_n[k] = 0;
          if (v) begin
            m_sum[k] = longint'(dv); m_n[k] = 1;
            if (m_n[k] == NPV[k]) m_ready[k] = 1;
          end
        end else if (m_ready[k]) begin
          t = (m_sum[k] + longint'(BSV[k])) >>> SHV[k];
          if (t < 0) m_q[k] = 0;
          else if (t > 32767) begin m_q[k] = 32767; m_ovf[k] = 1; end
          else m_q[k] = int'(t);
          m_valid[k] = 1; m_active[k] = 0; m_ready[k] = 0;
        end else if (m_active[k] && v) begin
          m_sum[k] += longint'(dv);
          m_n[k]++;
          if (m_n[k] == NPV[k]) m_ready[k] = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v, input int dv);
    rst = r; start = s; in_valid = v; d = 16'(dv);
    @(posedge clk);
    model_edge(r, s, v, 16'(dv));
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("valid", k, {31'b0, valid_w[k]}, {31'b0, m_valid[k]});
      chk("q",     k, {16'b0, q_w[k]},     32'(m_q[k]));
      chk("busy",  k, {31'b0, busy_w[k]},  {31'b0, m_active[k]});
      chk("ovf",   k, {31'b0, ovf_w[k]},   {31'b0, m_ovf[k]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  int px[$];

  task automatic run_pixel();
    step(0, 1, 0, 0);
    foreach (px[i]) begin
      idle(int'($urandom_range(0, 3)));
      step(0, 0, 1, px[i]);
    end
    idle(3);
  endtask

  initial begin
    int r_s, r_v, r_r;

    // Reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_q", 0, {16'b0, q_w[0]}, 32'd0);
    chk("rst_busy", 0, {31'b0, busy_w[0]}, 32'd0);

    // Basic sum
    px = '{10, 20, 30, 40, 50, 60};
    run_pixel();
    chk("sum210", 0, {16'b0, q_w[0]}, 32'd210);
    chk("sum210_ovf", 0, {31'b0, ovf_w[0]}, 32'd0);
    chk("sum210_busy", 0, {31'b0, busy_w[0]}, 32'd0);

    // ReLU to zero
    px = '{-500, 100, 100, 100, 100, 50};
    run_pixel();
    chk("relu0", 0, {16'b0, q_w[0]}, 32'd0);
    chk("relu0_ovf", 0, {31'b0, ovf_w[0]}, 32'd0);

    // High saturation sets sticky ovf
    px = '{32767, 32767, 32767, 32767, 32767, 32767};
    run_pixel();
    chk("sat", 0, {16'b0, q_w[0]}, 32'd32767);
    chk("sat_ovf", 0, {31'b0, ovf_w[0]}, 32'd1);

    // Bias and shift
    px = '{100, 100, 100, 100, 100, 100};
    run_pixel();
    chk("bias_shift", 1, {16'b0, q_w[1]}, 32'd125);
    chk("ovf_sticky", 0, {31'b0, ovf_w[0]}, 32'd1);
    px = '{0, 0, 0, 0, 0, 0};
    run_pixel();
    chk("neg_shift", 2, {16'b0, q_w[2]}, 32'd0);

    // Abort with start+in_valid restarting the pixel
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 7);
    step(0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    idle(2);
    chk("abort", 0, {16'b0, q_w[0]}, 32'd6);

    // Reset mid-accumulation, stray in_valid, then a clean pixel
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 300);
    step(1, 0, 0, 0);
    chk("midrst_q", 0, {16'b0, q_w[0]}, 32'd0);
    chk("midrst_ovf", 0, {31'b0, ovf_w[0]}, 32'd0);
    chk("midrst_busy", 0, {31'b0, busy_w[0]}, 32'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 99);
    px = '{1, 2, 3, 4, 5, 6};
    run_pixel();
    chk("after_rst", 0, {16'b0, q_w[0]}, 32'd21);

    // Single-partial configuration
    step(0, 1, 1, 42);
    chk("np1_lat0", 3, {31'b0, valid_w[3]}, 32'd0);
    step(0, 0, 0, 0);
    chk("np1_valid", 3, {31'b0, valid_w[3]}, 32'd1);
    chk("np1_q", 3, {16'b0, q_w[3]}, 32'd42);
    step(0, 1, 1, 5);
    step(0, 1, 1, 9);
    chk("np1_suppr", 3, {31'b0, valid_w[3]}, 32'd0);
    step(0, 0, 0, 0);
    chk("np1_b2b", 3, {16'b0, q_w[3]}, 32'd9);
    idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r_r = int'($urandom_range(0, 63));
      r_s = int'($urandom_range(0, 9));
      r_v = int'($urandom_range(0, 1));
      step(r_r == 0, r_s == 0, r_v == 1, int'($urandom_range(0, 65535)) - 32768);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_post.md
Name: channel_post

Overview:
- Downstream stage of the 36-lane dot channel.
- Consumes the channel's scalar partial dot products, one per valid pulse.
- Accumulates NUM_PART partials into one output-pixel sum, then adds bias, arithmetic-shifts (requantize), applies ReLU and saturates back to `data_len`.
- Emits one result per output pixel with a one-cycle valid pulse toward the feature-map store.

Parameters:
- NUM_PART, 6: partial products per output pixel (1..15).
- BIAS, 0: signed bias, ACC_W bits, added once per pixel before the shift.
- SHIFT, 0: arithmetic right shift applied after the bias add (0..ACC_W-1).
- ACC_W, `data_len`+8: signed accumulator width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new pixel and discards any partial sum.
- in_valid  input  1  one-cycle pulse; `d` holds a valid partial product.
- d  input  `data_len`  signed partial product from the dot channel.
- busy  output  1  high from accepted start until the result is emitted.
- valid  output  1  one-cycle result strobe.
- q  output  `data_len`  result, non-negative, saturated.
- ovf  output  1  sticky: set when any result saturated high; cleared only by rst.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, acc=0, cnt=0, busy=0, valid=0, q=0, ovf=0. rst overrides every other input, including mid-accumulation.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - start -> ACC, acc=0, cnt=0, busy=1.
  - in_valid without a prior start is ignored and leaves no state change.
- ACC:
  - in_valid -> acc += sign-extend(d), cnt += 1.
  - When the accepted input makes cnt reach NUM_PART -> OUT.
- start in ACC or OUT: abort; acc=0, cnt=0, stay or enter ACC.
- start and in_valid in the same cycle (any state): start clears first, then the d of that cycle is accumulated as partial #1 (acc=d, cnt=1). With NUM_PART=1 this goes directly to OUT.
- OUT (exactly one cycle):
  - t = (acc + BIAS) >>> SHIFT, computed at full ACC_W.
  - r = 0 if t<0; else 2^(`data_len`-1)-1 if t exceeds that value; else t.
  - q<=r, valid<=1, busy<=0, then -> IDLE. ovf<=1 if the high clamp applied.
  - in_valid during OUT is ignored. start during OUT takes priority: no valid is emitted and the block enters ACC.
- Latency: valid rises at the edge after the edge that accepted the NUM_PART-th in_valid, so valid is seen one cycle after that partial.
- q holds its last value until the next result; valid is never high two cycles in a row.
- Accumulator overflow cannot occur: ACC_W ≥ `data_len`+ceil(log2(NUM_PART))+1 must hold. Implementations check this at elaboration and stop on violation.
- cnt is 4 bits and never wraps; state returns to IDLE after OUT.

Decomposition:
- `data_len` comes from the shared num_data.v include.
- Add `define NUM_PART_DEFAULT 6 there, so the dot channel's inner count and this block agree.
- FSM state encodings are localparams, not shared.
- One natural sub-module: relu_sat, a combinational block (ACC_W signed in -> `data_len` out + clamp flag) implementing the shift/ReLU/saturate step. It is reusable by the pooling stage.

Test Plan (data_len=16, NUM_PART=6 unless noted):
- BIAS=0, SHIFT=0; start, then d=10,20,30,40,50,60 with gaps of 0-3 idle cycles -> one valid pulse, q=210, ovf=0, busy low after the pulse.
- d=-500,100,100,100,100,50 -> q=0 (ReLU), ovf=0; then six d=32767 -> q=32767, ovf=1, and ovf stays 1 through further normal pixels.
- BIAS=-100, SHIFT=2; six d=100 -> (600-100)>>>2 gives q=125. Then BIAS=-1, SHIFT=1; six d=0 -> -1>>>1=-1, so q=0.
- start, three partials of 7, then start together with in_valid d=1, then five d=1 -> q=6. No valid is emitted for the aborted pixel.
- rst asserted after four partials -> valid/busy/q/ovf all 0 next cycle. Later in_valid without start -> no valid ever. A new full pixel afterwards yields the correct sum.
- NUM_PART=1: start with in_valid d=42 in the same cycle -> valid with q=42 one cycle later. Back-to-back pixels with start issued in the OUT cycle -> the first result is suppressed and the second is correct.
